rr_req_gnt_arbiter: RTL
=======================

Name: rr_req_gnt_arbiter

Overview:
- Round-robin arbiter that shares one resource between NUM_REQ requesters using a pulsed req/gnt handshake.
- Each requester pulses req for one cycle. The arbiter latches it as pending and later answers with a one-cycle gnt pulse, followed by a mandatory gnt-low gap.
- Sits between requester agents and the shared resource. Uncontended timing is req@t, gnt@t+1, gnt low@t+2.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- GAP_CYCLES, 1, gnt-low cycles forced after every grant (1..15).
- ID_W, $clog2(NUM_REQ), width of gnt_id_op.

Ports:
- clk_ip  input  1  clock; all logic on posedge.
- reset_ip  input  1  synchronous, active-high reset.
- req_ip  input  NUM_REQ  per-requester request pulse; bit i high for one cycle = one request.
- gnt_op  output  NUM_REQ  one-hot grant pulse, registered.
- gnt_id_op  output  ID_W  index of current/last granted requester, registered.
- busy_op  output  1  high in GRANT and GAP states.
- pending_op  output  NUM_REQ  latched, not-yet-granted requests.
- dup_req_op  output  1  sticky; set when req_ip[i] arrives while pending[i] is already set.

Behaviour:
- Reset: synchronous on reset_ip=1 at a clock edge.
  - gnt_op=0, gnt_id_op=0, busy_op=0, pending_op=0, dup_req_op=0, rr_ptr=0, gap counter=0, state IDLE.
- Reset mid-GRANT or mid-GAP: gnt_op is 0 from the next edge. All pending requests are discarded, not replayed.
- Pending: pending[i] is set by req_ip[i] and cleared when gnt_op[i] is driven.
  - If req_ip[i] coincides with the cycle gnt_op[i] is high, pending[i] stays/becomes set, because it is a new request.
  - A req_ip[i] while pending[i]=1 is coalesced and sets dup_req_op.
- Eligible vector: eligible = pending | req_ip. A request is eligible in its own arrival cycle.
- Pick logic: first set bit of eligible, searching from rr_ptr upward with wrap-around (NUM_REQ-1 -> 0). After a grant to index k, rr_ptr = (k+1) mod NUM_REQ.
- FSM, one state register:
  - IDLE: if eligible!=0, go to GRANT and register gnt_op=onehot(pick), gnt_id_op=pick. Otherwise stay in IDLE.
  - GRANT (exactly one cycle): gnt_op one-hot high, busy_op=1. Load gap counter with GAP_CYCLES-1 and go to GAP.
  - GAP: gnt_op=0, busy_op=1. Decrement the counter each cycle. In the cycle the counter is 0:
    - if eligible!=0, go directly to GRANT with a new pick;
    - otherwise go to IDLE.
- Throughput under full contention: one grant every GAP_CYCLES+1 cycles.
- Latency: one cycle from req (in IDLE) to gnt. Under contention, worst case is (NUM_REQ-1)*(GAP_CYCLES+1)+1 cycles.
- Invariants:
  - gnt_op is always 0 or one-hot.
  - gnt_op is never high two consecutive cycles.
  - No requester is starved.
- gnt_id_op holds its value through GAP and IDLE.

Decomposition:
- Package rr_arb_pkg holds:
  - the state enum (IDLE, GRANT, GAP);
  - constant MAX_REQ=16;
  - the gap-counter width constant (4 bits).
- One sub-module: rr_priority_pick. It is combinational: inputs eligible and rr_ptr; outputs a valid flag and the pick index. It uses a rotate, priority-encode, un-rotate structure.

Test Plan:
- Single req: req_ip=0001 at cycle 10 -> gnt_op=0001 at 11, gnt_op=0 at 12, busy_op=1 at 11–12, IDLE at 13, pending_op=0 at 11.
- All-four contention: req_ip=1111 at cycle 5, GAP_CYCLES=1 -> grants to 0,1,2,3 at cycles 6,8,10,12; busy_op drops at 14.
- Wrap-around: after grant to 2, req_ip=1001 -> grant to 3 first, then to 0 two cycles later.
- Duplicate/coincident req:
  - req_ip[1] twice while pending -> dup_req_op=1 (sticky), single grant only.
  - req_ip[1] during its own gnt cycle -> second grant follows after the gap.
- Reset mid-operation: req_ip=0110 at cycle 3, reset_ip=1 at cycle 5 -> at cycle 6 all outputs are 0 and pending_op=0. No grants follow without new requests.
- GAP_CYCLES=3: req_ip=0011 at cycle 0 -> gnt_op=0001 at 1, gnt_op=0010 at 5; gnt_op=0 at cycles 2–4.

Source files
------------

// File: rtl/rr_req_gnt_arbiter_pkg.sv
// Shared types and constants for the round-robin request/grant arbiter.
package rr_arb_pkg;

  localparam int MAX_REQ   = 16;
  localparam int GAP_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set bit of eligible_i at or above rr_ptr_i, wrapping.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    pick_o
);

  localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rot_w;
  logic [ID_W-1:0]    enc_w;
  logic [ID_W:0]      sum_w;

  // Rotate so rr_ptr_i lands at bit 0; the pointer never reaches NUM_REQ, so one wrap suffices.
  always_comb begin
    rot_w = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int j;
      j = i + int'(rr_ptr_i);
      if (j >= NUM_REQ) j = j - NUM_REQ;
      rot_w[i] = eligible_i[j];
    end
  end

  always_comb begin
    enc_w = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (rot_w[i]) enc_w = ID_W'(i);
    end
  end

  always_comb begin
    sum_w = {1'b0, enc_w} + {1'b0, rr_ptr_i};
    if (sum_w >= NREQ_W) sum_w = sum_w - NREQ_W;
  end

  assign valid_o = |eligible_i;
  assign pick_o  = sum_w[ID_W-1:0];

endmodule

// File: rtl/rr_req_gnt_arbiter.sv
// Round-robin arbiter with pulsed req/gnt handshake: latches request pulses as pending,
// answers with one-cycle one-hot grants separated by a fixed gnt-low gap.
module rr_req_gnt_arbiter
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 1,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic               clk_ip,
  input  logic               reset_ip,
  input  logic [NUM_REQ-1:0] req_ip,
  output logic [NUM_REQ-1:0] gnt_op,
  output logic [ID_W-1:0]    gnt_id_op,
  output logic               busy_op,
  output logic [NUM_REQ-1:0] pending_op,
  output logic               dup_req_op
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("rr_req_gnt_arbiter: NUM_REQ out of range");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > (1 << GAP_CNT_W) - 1) begin : g_bad_gap
    $error("rr_req_gnt_arbiter: GAP_CYCLES out of range");
  end

  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYCLES - 1);
  localparam logic [ID_W-1:0]      LAST_IDX = ID_W'(NUM_REQ - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [ID_W-1:0]        gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic [GAP_CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     pend_q, pend_d;
  logic                   dup_q, dup_d;

  logic                   pick_vld;
  logic [ID_W-1:0]        pick_idx;
  logic [NUM_REQ-1:0]     pick_onehot;
  logic [ID_W-1:0]        pick_next_ptr;
  logic                   issue;

  // A request is eligible in its own arrival cycle, not only once latched.
  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .eligible_i (pend_q | req_ip),
    .rr_ptr_i   (ptr_q),
    .valid_o    (pick_vld),
    .pick_o     (pick_idx)
  );

  assign pick_onehot   = NUM_REQ'(1) << pick_idx;
  assign pick_next_ptr = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;

  always_comb begin
    state_d  = state_q;
    gnt_d    = '0;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q | req_ip;
    dup_d    = dup_q | (|(req_ip & pend_q));
    issue    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) issue = 1'b1;
      end
      ST_GRANT: begin
        cnt_d   = GAP_LOAD;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          if (pick_vld) issue = 1'b1;
          else          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The request consumed by this grant is the one seen now; a later pulse re-arms pending.
    if (issue) begin
      state_d  = ST_GRANT;
      gnt_d    = pick_onehot;
      gnt_id_d = pick_idx;
      ptr_d    = pick_next_ptr;
      pend_d   = pend_d & ~pick_onehot;
    end
  end

  always_ff @(posedge clk_ip) begin
    if (reset_ip) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      dup_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      dup_q    <= dup_d;
    end
  end

  assign gnt_op     = gnt_q;
  assign gnt_id_op  = gnt_id_q;
  assign busy_op    = (state_q == ST_GRANT) || (state_q == ST_GAP);
  assign pending_op = pend_q;
  assign dup_req_op = dup_q;

endmodule
